// File: rtl/bcd_pkg.sv
// BCD price type shared by the order book and its clients.
package bcd_pkg;

  localparam int unsigned PriceDigits = 4;

  typedef logic [4*PriceDigits-1:0] price_t;

endpackage

// File: rtl/ob_pkg.sv
// Order-book command/response types and client constants.
package ob_pkg;

  localparam int unsigned UidW    = 8;
  localparam int unsigned QtyW    = 16;
  localparam int unsigned OprandW = QtyW + $bits(bcd_pkg::price_t);

  typedef logic [UidW-1:0]    uid_t;
  typedef logic [QtyW-1:0]    quantity_t;
  typedef logic [OprandW-1:0] oprand_t;

  typedef enum logic [2:0] {
    Nop       = 3'd0,
    Buy       = 3'd1,
    Sell      = 3'd2,
    Cancel    = 3'd3,
    QryBidAsk = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    S_Ok     = 2'd0,
    S_Trade  = 2'd1,
    S_Reject = 2'd2
  } status_t;

  typedef struct packed {
    uid_t    uid;
    opcode_t opcode;
    oprand_t oprand;
  } cmd_t;

  typedef struct packed {
    uid_t              uid;
    status_t           status;
    quantity_t         quantity;
    bcd_pkg::price_t   price;
  } rsp_t;

  localparam logic [31:0] TradeCntMax  = '1;
  localparam logic [15:0] OrphanCntMax = '1;

  function automatic oprand_t build_oprand(input opcode_t op, input quantity_t qty,
                                           input bcd_pkg::price_t price, input uid_t uid);
    oprand_t res;
    res = '0;
    case (op)
      Buy, Sell: res = {qty, price};
      Cancel:    res = oprand_t'(uid);
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ob_client_tbl.sv
// In-flight uid table: lowest-free allocation, free-by-uid, match and occupancy count.
module ob_client_tbl
  import ob_pkg::*;
#(
  parameter int unsigned N_OUT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_alloc,
  input  uid_t                         i_alloc_uid,
  input  logic                         i_free,
  input  uid_t                         i_free_uid,
  output logic                         o_match,
  output logic [$clog2(N_OUT+1)-1:0]   o_count
);

  localparam int unsigned CntW = $clog2(N_OUT + 1);

  logic [N_OUT-1:0]       r_vld;
  uid_t [N_OUT-1:0]       r_uid;
  logic [N_OUT-1:0]       w_alloc_sel;
  logic [N_OUT-1:0]       w_free_sel;

  // Both selections look only at pre-edge state, so a slot freed this cycle is
  // not reused until the next one.
  always_comb begin
    w_alloc_sel = '0;
    w_free_sel  = '0;
    o_count     = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (!r_vld[i] && (w_alloc_sel == '0)) w_alloc_sel[i] = 1'b1;
      if (r_vld[i] && (r_uid[i] == i_free_uid) && (w_free_sel == '0)) w_free_sel[i] = 1'b1;
      o_count = o_count + CntW'(r_vld[i]);
    end
    o_match = |w_free_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_uid <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (i_alloc && w_alloc_sel[i]) begin
          r_vld[i] <= 1'b1;
          r_uid[i] <= i_alloc_uid;
        end else if (i_free && w_free_sel[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ob_client.sv
// Host-side order-book client: issues uid-tagged commands, tracks them in flight,
// and forwards order-book responses to the host as held completions.
module ob_client
  import ob_pkg::*;
#(
  parameter int unsigned N_OUT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_vld,
  input  opcode_t                     req_opcode,
  input  quantity_t                   req_quantity,
  input  bcd_pkg::price_t             req_price,
  input  uid_t                        req_cancel_uid,
  output logic                        req_rdy,
  output uid_t                        req_uid,
  output logic                        cmd_vld_r,
  output cmd_t                        cmd_r,
  input  logic                        cmd_full_r,
  input  logic                        rsp_vld,
  input  rsp_t                        rsp,
  output logic                        rsp_accept,
  output logic                        cpl_vld,
  output rsp_t                        cpl_rsp,
  output logic                        cpl_orphan,
  input  logic                        cpl_rdy,
  output logic [$clog2(N_OUT+1)-1:0]  inflight,
  output logic [31:0]                 trade_cnt,
  output logic [15:0]                 orphan_cnt
);

  localparam int unsigned CntW = $clog2(N_OUT + 1);
  localparam logic [CntW-1:0] NOutCnt = CntW'(N_OUT);

  uid_t        r_uid;
  logic        r_cmd_vld;
  cmd_t        r_cmd;
  logic        r_cpl_vld;
  rsp_t        r_cpl_rsp;
  logic        r_cpl_orphan;
  logic [31:0] r_trade_cnt;
  logic [15:0] r_orphan_cnt;

  logic        w_accept;
  logic        w_consume;
  logic        w_is_trade;
  logic        w_match;
  logic        w_orphan;

  always_comb begin
    req_rdy    = !rst && !cmd_full_r && (inflight < NOutCnt);
    rsp_accept = !rst && (!r_cpl_vld || cpl_rdy);
    w_accept   = req_vld && req_rdy;
    w_consume  = rsp_vld && rsp_accept;
    w_is_trade = (rsp.status == S_Trade);
    w_orphan   = !w_is_trade && !w_match;
  end

  ob_client_tbl #(
    .N_OUT (N_OUT)
  ) u_tbl (
    .clk         (clk),
    .rst         (rst),
    .i_alloc     (w_accept),
    .i_alloc_uid (r_uid),
    .i_free      (w_consume && !w_is_trade),
    .i_free_uid  (rsp.uid),
    .o_match     (w_match),
    .o_count     (inflight)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_uid        <= '0;
      r_cmd_vld    <= 1'b0;
      r_cmd        <= '0;
      r_cpl_vld    <= 1'b0;
      r_cpl_rsp    <= '0;
      r_cpl_orphan <= 1'b0;
      r_trade_cnt  <= '0;
      r_orphan_cnt <= '0;
    end else begin
      r_cmd_vld <= w_accept;
      if (w_accept) begin
        r_uid <= r_uid + 1'b1;
        r_cmd <= '{uid:    r_uid,
                   opcode: req_opcode,
                   oprand: build_oprand(req_opcode, req_quantity, req_price, req_cancel_uid)};
      end
      if (w_consume) begin
        r_cpl_vld    <= 1'b1;
        r_cpl_rsp    <= rsp;
        r_cpl_orphan <= w_orphan;
        if (w_is_trade && (r_trade_cnt != TradeCntMax)) r_trade_cnt <= r_trade_cnt + 1'b1;
        if (w_orphan && (r_orphan_cnt != OrphanCntMax)) r_orphan_cnt <= r_orphan_cnt + 1'b1;
      end else if (cpl_rdy) begin
        r_cpl_vld <= 1'b0;
      end
    end
  end

  assign req_uid    = r_uid;
  assign cmd_vld_r  = r_cmd_vld;
  assign cmd_r      = r_cmd;
  assign cpl_vld    = r_cpl_vld;
  assign cpl_rsp    = r_cpl_rsp;
  assign cpl_orphan = r_cpl_orphan;
  assign trade_cnt  = r_trade_cnt;
  assign orphan_cnt = r_orphan_cnt;

endmodule

// File: tb/tb_ob_client.sv
// Directed bench for ob_client: opcode vector table plus hand-written flow sequences.
module tb_ob_client;
  import ob_pkg::*;

  localparam int unsigned NOut = 4;
  localparam int unsigned CntW = $clog2(NOut + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            req_vld;
  opcode_t         req_opcode;
  quantity_t       req_quantity;
  bcd_pkg::price_t req_price;
  uid_t            req_cancel_uid;
  logic            req_rdy;
  uid_t            req_uid;
  logic            cmd_vld_r;
  cmd_t            cmd_r;
  logic            cmd_full_r;
  logic            rsp_vld;
  rsp_t            rsp;
  logic            rsp_accept;
  logic            cpl_vld;
  rsp_t            cpl_rsp;
  logic            cpl_orphan;
  logic            cpl_rdy;
  logic [CntW-1:0] inflight;
  logic [31:0]     trade_cnt;
  logic [15:0]     orphan_cnt;

  always #5 clk = ~clk;

  ob_client #(.N_OUT(NOut)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_opcode(req_opcode),
    .req_quantity(req_quantity), .req_price(req_price), .req_cancel_uid(req_cancel_uid),
    .req_rdy(req_rdy), .req_uid(req_uid), .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r),
    .cmd_full_r(cmd_full_r), .rsp_vld(rsp_vld), .rsp(rsp), .rsp_accept(rsp_accept),
    .cpl_vld(cpl_vld), .cpl_rsp(cpl_rsp), .cpl_orphan(cpl_orphan), .cpl_rdy(cpl_rdy),
    .inflight(inflight), .trade_cnt(trade_cnt), .orphan_cnt(orphan_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    opcode_t         op;
    quantity_t       qty;
    bcd_pkg::price_t price;
    uid_t            cuid;
    uid_t            exp_uid;
    oprand_t         exp_oprand;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic rsp_t mk_rsp(input uid_t u, input status_t s);
    rsp_t r;
    r = '{uid: u, status: s, quantity: 16'h0042, price: 16'h0999};
    return r;
  endfunction

  task automatic idle_inputs();
    req_vld        = 1'b0;
    req_opcode     = Nop;
    req_quantity   = '0;
    req_price      = '0;
    req_cancel_uid = '0;
    cmd_full_r     = 1'b0;
    rsp_vld        = 1'b0;
    rsp            = '0;
    cpl_rdy        = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive_req(input opcode_t op, input quantity_t q, input bcd_pkg::price_t p,
                           input uid_t cu);
    req_vld        = 1'b1;
    req_opcode     = op;
    req_quantity   = q;
    req_price      = p;
    req_cancel_uid = cu;
  endtask

  initial begin
    vecs[0] = '{Sell,      16'd3,  16'h2599, 8'h00, 8'd0, 32'h0003_2599};
    vecs[1] = '{Cancel,    16'd7,  16'h1234, 8'h55, 8'd1, 32'h0000_0055};
    vecs[2] = '{Nop,       16'd9,  16'h4321, 8'h66, 8'd2, 32'h0000_0000};
    vecs[3] = '{QryBidAsk, 16'd11, 16'h0050, 8'h77, 8'd3, 32'h0000_0000};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    step();
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_rsp_accept", 64'(rsp_accept), 64'd0);
    step();
    chk("rst_cmd_vld", 64'(cmd_vld_r), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_cpl_vld", 64'(cpl_vld), 64'd0);
    chk("rst_trade_cnt", 64'(trade_cnt), 64'd0);
    rst = 1'b0;

    // Single buy: one-cycle command latency
    drive_req(Buy, 16'd10, 16'h0100, 8'h00);
    settle();
    chk("buy_req_rdy", 64'(req_rdy), 64'd1);
    chk("buy_req_uid", 64'(req_uid), 64'd0);
    step();
    req_vld = 1'b0;
    chk("buy_cmd_vld", 64'(cmd_vld_r), 64'd1);
    chk("buy_cmd_uid", 64'(cmd_r.uid), 64'd0);
    chk("buy_cmd_op", 64'(cmd_r.opcode), 64'(Buy));
    chk("buy_oprand", 64'(cmd_r.oprand), 64'h0000_0000_000a_0100);
    chk("buy_inflight", 64'(inflight), 64'd1);
    step();
    chk("buy_cmd_vld_drop", 64'(cmd_vld_r), 64'd0);

    // Opcode table, back to back until the table fills
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_req(vecs[i].op, vecs[i].qty, vecs[i].price, vecs[i].cuid);
      settle();
      chk("tbl_req_rdy", 64'(req_rdy), 64'd1);
      chk("tbl_req_uid", 64'(req_uid), 64'(vecs[i].exp_uid));
      step();
      chk("tbl_cmd_vld", 64'(cmd_vld_r), 64'd1);
      chk("tbl_cmd_uid", 64'(cmd_r.uid), 64'(vecs[i].exp_uid));
      chk("tbl_cmd_op", 64'(cmd_r.opcode), 64'(vecs[i].op));
      chk("tbl_oprand", 64'(cmd_r.oprand), 64'(vecs[i].exp_oprand));
      chk("tbl_inflight", 64'(inflight), 64'(i + 1));
    end
    drive_req(Buy, 16'd1, 16'h0001, 8'h00);
    settle();
    chk("full_req_rdy", 64'(req_rdy), 64'd0);
    step();
    chk("full_cmd_vld", 64'(cmd_vld_r), 64'd0);
    chk("full_req_uid", 64'(req_uid), 64'd4);
    chk("full_inflight", 64'(inflight), 64'd4);
    req_vld = 1'b0;

    // Completion backpressure
    rsp_vld = 1'b1;
    rsp     = mk_rsp(8'd2, S_Ok);
    cpl_rdy = 1'b0;
    settle();
    chk("bp_accept_empty", 64'(rsp_accept), 64'd1);
    step();
    chk("bp_cpl_vld", 64'(cpl_vld), 64'd1);
    chk("bp_cpl_uid", 64'(cpl_rsp.uid), 64'd2);
    chk("bp_inflight", 64'(inflight), 64'd3);
    rsp = mk_rsp(8'd3, S_Ok);
    settle();
    chk("bp_accept_held", 64'(rsp_accept), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_hold_vld", 64'(cpl_vld), 64'd1);
      chk("bp_hold_uid", 64'(cpl_rsp.uid), 64'd2);
      chk("bp_hold_inflight", 64'(inflight), 64'd3);
    end
    cpl_rdy = 1'b1;
    settle();
    chk("bp_accept_rdy", 64'(rsp_accept), 64'd1);
    step();
    chk("bp_next_uid", 64'(cpl_rsp.uid), 64'd3);
    chk("bp_next_inflight", 64'(inflight), 64'd2);

    // Allocate and free in the same cycle, then refill
    rsp = mk_rsp(8'd0, S_Ok);
    drive_req(Buy, 16'd5, 16'h0200, 8'h00);
    settle();
    chk("af_req_uid", 64'(req_uid), 64'd4);
    step();
    rsp_vld = 1'b0;
    chk("af_inflight", 64'(inflight), 64'd2);
    chk("af_cmd_uid", 64'(cmd_r.uid), 64'd4);
    chk("af_cpl_uid", 64'(cpl_rsp.uid), 64'd0);
    step();
    chk("af_fill1", 64'(inflight), 64'd3);
    step();
    chk("af_fill2", 64'(inflight), 64'd4);
    chk("af_fill2_uid", 64'(cmd_r.uid), 64'd6);
    settle();
    chk("af_full_rdy", 64'(req_rdy), 64'd0);
    req_vld = 1'b0;

    // Trades leave the table alone
    do_reset();
    drive_req(Buy, 16'd10, 16'h0100, 8'h00);
    step();
    req_vld = 1'b0;
    rsp_vld = 1'b1;
    rsp     = mk_rsp(8'd0, S_Trade);
    step();
    chk("tr1_cnt", 64'(trade_cnt), 64'd1);
    chk("tr1_inflight", 64'(inflight), 64'd1);
    chk("tr1_orphan", 64'(cpl_orphan), 64'd0);
    step();
    chk("tr2_cnt", 64'(trade_cnt), 64'd2);
    chk("tr2_inflight", 64'(inflight), 64'd1);
    rsp = mk_rsp(8'd0, S_Reject);
    step();
    rsp_vld = 1'b0;
    chk("tr3_cnt", 64'(trade_cnt), 64'd2);
    chk("tr3_inflight", 64'(inflight), 64'd0);
    chk("tr3_status", 64'(cpl_rsp.status), 64'(S_Reject));
    chk("tr3_orphan", 64'(cpl_orphan), 64'd0);
    step();
    chk("tr_cpl_drop", 64'(cpl_vld), 64'd0);

    // Orphan response
    drive_req(Buy, 16'd1, 16'h0001, 8'h00);
    step();
    req_vld = 1'b0;
    rsp_vld = 1'b1;
    rsp     = mk_rsp(8'd9, S_Ok);
    step();
    rsp_vld = 1'b0;
    chk("orph_flag", 64'(cpl_orphan), 64'd1);
    chk("orph_cnt", 64'(orphan_cnt), 64'd1);
    chk("orph_inflight", 64'(inflight), 64'd1);

    // Command-side backpressure
    cmd_full_r = 1'b1;
    drive_req(Sell, 16'd2, 16'h0300, 8'h00);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("cf_req_rdy", 64'(req_rdy), 64'd0);
      step();
      chk("cf_cmd_vld", 64'(cmd_vld_r), 64'd0);
      chk("cf_req_uid", 64'(req_uid), 64'd2);
    end
    cmd_full_r = 1'b0;
    step();
    chk("cf_release_vld", 64'(cmd_vld_r), 64'd1);
    chk("cf_release_uid", 64'(cmd_r.uid), 64'd2);
    chk("cf_inflight", 64'(inflight), 64'd2);

    // Mid-flight reset discards tracking
    rsp_vld = 1'b1;
    rsp     = mk_rsp(8'd1, S_Ok);
    rst     = 1'b1;
    settle();
    chk("mr_req_rdy", 64'(req_rdy), 64'd0);
    chk("mr_rsp_accept", 64'(rsp_accept), 64'd0);
    step();
    chk("mr_cmd_vld", 64'(cmd_vld_r), 64'd0);
    chk("mr_cmd", 64'(cmd_r), 64'd0);
    chk("mr_cpl_vld", 64'(cpl_vld), 64'd0);
    chk("mr_cpl_rsp", 64'(cpl_rsp), 64'd0);
    chk("mr_cpl_orphan", 64'(cpl_orphan), 64'd0);
    chk("mr_inflight", 64'(inflight), 64'd0);
    chk("mr_req_uid", 64'(req_uid), 64'd0);
    chk("mr_trade_cnt", 64'(trade_cnt), 64'd0);
    chk("mr_orphan_cnt", 64'(orphan_cnt), 64'd0);
    rst     = 1'b0;
    req_vld = 1'b0;
    step();
    rsp_vld = 1'b0;
    chk("mr_old_orphan", 64'(cpl_orphan), 64'd1);
    chk("mr_old_orphan_cnt", 64'(orphan_cnt), 64'd1);
    chk("mr_old_inflight", 64'(inflight), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
